// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU internal data bus: arbiter state encoding
// and source indices.
package cpu_bus_pkg;

    // Arbiter ownership states (2-bit encoding).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Source indices; also the bus mux select values.
    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    // Bus byte width.
    localparam int BUS_W = 8;

    // Ownership state that grants a given source.
    function automatic arb_state_e own_state(input logic src);
        return (src == SRC1) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/bus_arbiter8_mux.sv
// 2:1 bus mux, one bit-slice per data bit; sel = 0 picks a, sel = 1 picks b.
module bus_arbiter8_mux #(
    parameter int VEC_W = 8
) (
    input  logic [VEC_W-1:0] a,
    input  logic [VEC_W-1:0] b,
    input  logic             sel,
    output logic [VEC_W-1:0] y
);

    // Purely combinational select, replicated per bit.
    for (genvar i = 0; i < VEC_W; i++) begin : g_bit
        assign y[i] = sel ? b[i] : a[i];
    end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter for the shared 8-bit internal data bus. Two sources,
// one consumer with a valid/ready handshake; ownership is released on the
// last beat, on an abandoned request, or after MAX_BURST beats.
module bus_arbiter8
    import cpu_bus_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [BUS_W-1:0] data0,
    input  logic [BUS_W-1:0] data1,
    input  logic             last0,
    input  logic             last1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [BUS_W-1:0] bus_data,
    output logic             bus_valid,
    input  logic             bus_ready,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e    state_q, state_d;
    logic          prio_q, prio_d;
    logic          sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;

    logic own;        // a grant is held
    logic own_src;    // which source owns the bus (valid when own)
    logic cur_req;
    logic cur_last;
    logic oth_req;
    logic beat;
    logic expire;     // this beat is the MAX_BURST-th of the grant
    logic rel;        // ownership ends at this edge

    assign own      = (state_q != IDLE);
    assign own_src  = (state_q == OWN1) ? SRC1 : SRC0;
    assign cur_req  = (own_src == SRC1) ? req1  : req0;
    assign cur_last = (own_src == SRC1) ? last1 : last0;
    assign oth_req  = (own_src == SRC1) ? req0  : req1;

    // Valid follows the owner's request directly, so a dropped request
    // removes valid in the same cycle.
    assign bus_valid = own & cur_req;
    assign beat      = bus_valid & bus_ready;
    assign cnt_inc   = cnt_q + 1'b1;
    assign expire    = (cnt_inc == CW'(MAX_BURST));
    assign rel       = own & (~cur_req | (beat & (cur_last | expire)));

    // Grants and busy come straight from the state register.
    assign gnt0 = (state_q == OWN0);
    assign gnt1 = (state_q == OWN1);
    assign busy = own;
    assign sel  = sel_q;

    // State, pointer, select and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= SRC0;
            sel_q   <= SRC0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: grant in IDLE, release/hand-over/re-grant while owning.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req0 && req1) state_d = own_state(prio_q);
                else if (req0)    state_d = OWN0;
                else if (req1)    state_d = OWN1;
            end
            OWN0, OWN1: begin
                if (rel) begin
                    // Any release hands priority to the other source. A pure
                    // timeout with nobody else waiting re-grants the owner.
                    prio_d = ~own_src;
                    cnt_d  = '0;
                    if (oth_req)               state_d = own_state(~own_src);
                    else if (beat && !cur_last) state_d = state_q;
                    else                       state_d = IDLE;
                end else if (beat) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Select tracks the next owner and holds its last value through IDLE.
    always_comb begin
        sel_d = sel_q;
        if (state_d == OWN0)      sel_d = SRC0;
        else if (state_d == OWN1) sel_d = SRC1;
    end

    bus_arbiter8_mux #(.VEC_W(BUS_W)) u_mux (
        .a   (data0),
        .b   (data1),
        .sel (sel_q),
        .y   (bus_data)
    );

endmodule

// File: doc/bus_arbiter8.md
# bus_arbiter8

Two-requester arbiter for the CPU's shared 8-bit internal data bus. Grants one source at a time, drives the select of the 8-bit 2:1 bus mux, and forwards the granted source's byte to the single bus consumer (register file / ALU operand latch) with a valid/ready handshake. Ownership is round-robin, released on end-of-transfer or after a bounded burst.

## Interface
Parameters:
- MAX_BURST, 8: maximum beats per grant before forced release; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req0 / req1  in  1  request from source 0 / 1; held until its last beat transfers.
- data0 / data1  in  8  byte offered by source 0 / 1.
- last0 / last1  in  1  current byte is the final beat of the transfer.
- gnt0 / gnt1  out  1  registered grant; at most one high.
- sel  out  1  bus mux select; 0 = source 0, 1 = source 1.
- bus_data  out  8  sel ? data1 : data0.
- bus_valid  out  1  byte on bus_data is valid.
- bus_ready  in  1  consumer accepts the byte this cycle.
- busy  out  1  high whenever a grant is held.

## Operation
- States: IDLE, OWN0, OWN1. Priority pointer prio (1 bit): the source that wins a simultaneous request.
- IDLE: req0 & ~req1 -> OWN0; req1 & ~req0 -> OWN1; both -> OWN{prio}; neither -> stay.
- OWNx: gntx = 1, sel = x, busy = 1. bus_valid = reqx (combinational, gated by state). Beat = bus_valid & bus_ready; each beat increments beat counter cnt.
- Release condition in OWNx (any of): beat with lastx; beat with cnt+1 == MAX_BURST; reqx low (abandon, no beat counted).
- On release: prio <= other source; next state = OWN{other} if req{other}, else OWN{x} if reqx still high (timeout case only), else IDLE. cnt <= 0 on every state change or re-grant.
- No release -> remain, cnt held when no beat.
- sel holds its last value in IDLE; bus_data is always the combinational mux of data0/data1 by sel.
- cnt width: $clog2(MAX_BURST+1); never exceeds MAX_BURST-1 at rest.

## Timing
- Reset (asynchronous, immediate): state IDLE, gnt0 = gnt1 = 0, sel = 0, prio = 0, cnt = 0, busy = 0, bus_valid = 0.
- Grant latency: request seen in IDLE at edge N -> gnt high after edge N (one cycle). First beat possible in that same granted cycle.
- Hand-over with no bubble: release beat at edge M with other requesting -> other's grant high after edge M; no IDLE cycle.
- bus_ready low stalls: bus_data and bus_valid held by the source; grant held indefinitely (no timeout on stall, only on beats).
- last and counter expiry on the same beat: single release, pointer flips once.
- rst_n asserted mid-burst: grant drops asynchronously; the in-flight beat is lost; sources re-request after reset.
- req dropped mid-grant: bus_valid falls same cycle; state leaves OWNx at next edge.

## Structure
- Shared package (cpu_bus_pkg): state encoding constants IDLE/OWN0/OWN1 (2-bit), source-index constants SRC0 = 0, SRC1 = 1.
- One sub-module: the team's existing 8-bit 2:1 mux instantiated for bus_data, with sel on its select input. Controller FSM, pointer and counter stay in this module.

## Test plan
- Reset then req0 alone with data0 = 0x3C, last0 = 1, bus_ready = 1 -> gnt0 one cycle later, bus_data = 0x3C, bus_valid = 1 for one cycle, return to IDLE, prio = 1.
- req0 and req1 rise together from reset -> source 0 granted first (prio 0); after its last beat, gnt1 high next cycle with no idle gap; then a second simultaneous request grants source 0 again.
- MAX_BURST = 4, req1 streams 0x01..0x06 with last only on 0x06, req0 also pending -> after 4 beats (0x01..0x04) grant switches to source 0; source 1 regains grant after source 0 finishes and completes 0x05, 0x06.
- MAX_BURST = 4, only req1 streaming 6 beats -> re-grant to source 1 after beat 4 without visiting IDLE, cnt resets, all 6 bytes delivered in order.
- Grant held with bus_ready low for 10 cycles -> bus_valid stays high, no release, cnt unchanged; ready high -> beat completes.
- rst_n pulsed low mid-burst while gnt1 high -> gnt1, busy, bus_valid drop immediately (before next edge), sel = 0, prio = 0.
